// File: rtl/modulo_escalonador_contador.sv
// Queues countdown presets in a small FIFO and sequences the counter datapath (load, run, clear) one request at a time.
// Optional RUN watchdog enabled by defining MODULO_ESCALONADOR_WATCHDOG_EN.
module modulo_escalonador_contador #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       req_valid,
  input  logic [DATA_W-1:0]          req_data,
  output logic                       req_ready,
  input  logic                       cnt_zero,
  input  logic                       abort,
  output logic [DATA_W-1:0]          cnt_value,
  output logic                       Load_C,
  output logic                       Enable_C,
  output logic                       Clear_Reg,
  output logic                       busy,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10,
    CLEAR = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]   cnt_value_q, cnt_value_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic wd_fire;

  assign full       = (level_q == LVL_W'(DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = req_valid & ~full;

  // Storage is not reset; occupancy is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= req_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            state_d = LOAD;
            pop     = 1'b1;
          end
        end
        LOAD:  state_d = RUN;
        RUN: begin
          if (cnt_zero || abort || wd_fire) begin
            state_d = CLEAR;
          end
        end
        CLEAR: begin
          if (!fifo_empty) begin
            state_d = LOAD;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_value_d = pop ? mem[rd_ptr_q] : cnt_value_q;
    level_d     = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      cnt_value_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      cnt_value_q <= cnt_value_d;
    end
  end

`ifdef MODULO_ESCALONADOR_WATCHDOG_EN
  localparam int                WD_W    = DATA_W + 2;
  // Fires on the last of 2**DATA_W + 2 enabled RUN cycles.
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'((2 ** DATA_W) + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_q, timeout_d;

  assign wd_fire = (state_q == RUN) && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d  = wd_cnt_q;
    timeout_d = timeout_q;
    if (state_q != RUN) begin
      wd_cnt_d = '0;
    end else if (enable) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    if (enable) begin
      timeout_d = wd_fire && !cnt_zero && !abort;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  assign req_ready = ~full;
  assign empty     = fifo_empty;
  assign level     = level_q;
  assign cnt_value = cnt_value_q;
  assign busy      = (state_q != IDLE);
  assign Load_C    = enable & (state_q == LOAD);
  assign Enable_C  = enable & (state_q == RUN);
  assign Clear_Reg = enable & (state_q == CLEAR);

endmodule

// File: tb/tb_modulo_escalonador_contador.sv
// Directed bench for modulo_escalonador_contador: reset, single request, full queue, pause/abort,
// simultaneous push/pop, watchdog (MODULO_ESCALONADOR_WATCHDOG_EN aware).
module tb_modulo_escalonador_contador;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       req_valid;
  logic [3:0] req_data;
  logic       req_ready;
  logic       cnt_zero;
  logic       abort;
  logic [3:0] cnt_value;
  logic       Load_C;
  logic       Enable_C;
  logic       Clear_Reg;
  logic       busy;
  logic       empty;
  logic [2:0] level;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  modulo_escalonador_contador #(.DATA_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .cnt_zero(cnt_zero), .abort(abort), .cnt_value(cnt_value),
    .Load_C(Load_C), .Enable_C(Enable_C), .Clear_Reg(Clear_Reg),
    .busy(busy), .empty(empty), .level(level), .timeout(timeout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] v);
    req_valid = 1'b1;
    req_data  = v;
    tick();
    req_valid = 1'b0;
    $display("push %0d -> level=%0d req_ready=%b", v, level, req_ready);
  endtask

  task automatic test_reset_state();
    rst = 1'b0; enable = 1'b0; req_valid = 1'b0; req_data = '0; cnt_zero = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if ({empty, req_ready, busy} !== 3'b110) begin errors++; $display("FAIL reset_flags: empty,req_ready,busy=%b expected 110", {empty, req_ready, busy}); end
    checks++; if ({Load_C, Enable_C, Clear_Reg, timeout} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {Load_C, Enable_C, Clear_Reg, timeout}); end
    checks++; if (cnt_value !== 4'd0) begin errors++; $display("FAIL reset_cnt_value: got %0d expected 0", cnt_value); end
    rst = 1'b1;
    tick();
    $display("reset released");
  endtask

  task automatic test_single();
    enable = 1'b1;
    push(4'd5);
    checks++; if ({empty, busy, level} !== {1'b0, 1'b0, 3'd1}) begin errors++; $display("FAIL single_after_push: empty,busy,level=%b expected 00001", {empty, busy, level}); end
    tick();
    checks++; if ({Load_C, cnt_value, level} !== {1'b1, 4'd5, 3'd0}) begin errors++; $display("FAIL single_load: Load_C=%b cnt_value=%0d level=%0d expected 1/5/0", Load_C, cnt_value, level); end
    tick();
    for (int i = 1; i <= 5; i++) begin
      checks++; if ({Load_C, Enable_C} !== 2'b01) begin errors++; $display("FAIL single_run%0d: Load_C,Enable_C=%b expected 01", i, {Load_C, Enable_C}); end
      if (i == 5) cnt_zero = 1'b1;
      tick();
    end
    checks++; if ({Enable_C, Clear_Reg} !== 2'b01) begin errors++; $display("FAIL single_clear: Enable_C,Clear_Reg=%b expected 01", {Enable_C, Clear_Reg}); end
    cnt_zero = 1'b0;
    tick();
    checks++; if ({busy, Clear_Reg} !== 2'b00) begin errors++; $display("FAIL single_idle: busy,Clear_Reg=%b expected 00", {busy, Clear_Reg}); end
    $display("single request 5 served");
  endtask

  task automatic test_queue_full_back_to_back();
    enable = 1'b0;
    for (int k = 1; k <= 4; k++) push(4'(k));
    checks++; if ({req_ready, level} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_flags: req_ready=%b level=%0d expected 0/4", req_ready, level); end
    push(4'd9);
    checks++; if ({req_ready, level} !== {1'b0, 3'd4}) begin errors++; $display("FAIL full_reject: req_ready=%b level=%0d expected 0/4", req_ready, level); end
    enable = 1'b1;
    cnt_zero = 1'b1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      checks++; if ({Load_C, cnt_value} !== {1'b1, 4'(k)}) begin errors++; $display("FAIL b2b_load%0d: Load_C=%b cnt_value=%0d expected 1/%0d", k, Load_C, cnt_value, k); end
      tick();
      checks++; if (Enable_C !== 1'b1) begin errors++; $display("FAIL b2b_run%0d: Enable_C=%b expected 1", k, Enable_C); end
      tick();
      checks++; if ({Clear_Reg, busy} !== 2'b11) begin errors++; $display("FAIL b2b_clear%0d: Clear_Reg,busy=%b expected 11", k, {Clear_Reg, busy}); end
      tick();
      $display("served entry %0d", k);
    end
    checks++; if ({busy, empty, level} !== {1'b0, 1'b1, 3'd0}) begin errors++; $display("FAIL b2b_end: busy,empty,level=%b expected 01000", {busy, empty, level}); end
    cnt_zero = 1'b0;
  endtask

  task automatic test_pause_abort();
    enable = 1'b0;
    push(4'd7);
    push(4'd8);
    enable = 1'b1;
    tick();
    tick();
    checks++; if ({Enable_C, cnt_value} !== {1'b1, 4'd7}) begin errors++; $display("FAIL pause_run: Enable_C=%b cnt_value=%0d expected 1/7", Enable_C, cnt_value); end
    enable = 1'b0;
    #1;
    checks++; if (Enable_C !== 1'b0) begin errors++; $display("FAIL pause_gate: Enable_C=%b expected 0", Enable_C); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({busy, Load_C, Enable_C, Clear_Reg, cnt_value} !== {4'b1000, 4'd7}) begin errors++; $display("FAIL pause_hold%0d: busy,Load,En,Clr=%b cnt_value=%0d expected 1000/7", i, {busy, Load_C, Enable_C, Clear_Reg}, cnt_value); end
    end
    enable = 1'b1;
    #1;
    checks++; if (Enable_C !== 1'b1) begin errors++; $display("FAIL pause_resume: Enable_C=%b expected 1", Enable_C); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (Clear_Reg !== 1'b1) begin errors++; $display("FAIL abort_clear: Clear_Reg=%b expected 1", Clear_Reg); end
    tick();
    checks++; if ({Load_C, cnt_value} !== {1'b1, 4'd8}) begin errors++; $display("FAIL abort_next: Load_C=%b cnt_value=%0d expected 1/8", Load_C, cnt_value); end
    cnt_zero = 1'b1;
    repeat (3) tick();
    cnt_zero = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b expected 0", busy); end
    $display("pause/abort sequence done");
  endtask

  task automatic test_simultaneous_push_pop();
    enable = 1'b0;
    push(4'd1);
    push(4'd2);
    push(4'd3);
    enable = 1'b1;
    cnt_zero = 1'b1;
    repeat (3) tick();
    checks++; if ({Clear_Reg, level} !== {1'b1, 3'd2}) begin errors++; $display("FAIL simul_pre: Clear_Reg=%b level=%0d expected 1/2", Clear_Reg, level); end
    req_valid = 1'b1;
    req_data  = 4'hA;
    tick();
    req_valid = 1'b0;
    checks++; if ({Load_C, cnt_value, level} !== {1'b1, 4'd2, 3'd2}) begin errors++; $display("FAIL simul_pop: Load_C=%b cnt_value=%0d level=%0d expected 1/2/2", Load_C, cnt_value, level); end
    repeat (3) tick();
    checks++; if (cnt_value !== 4'd3) begin errors++; $display("FAIL simul_second: cnt_value=%0d expected 3", cnt_value); end
    repeat (3) tick();
    checks++; if ({Load_C, cnt_value, level} !== {1'b1, 4'hA, 3'd0}) begin errors++; $display("FAIL simul_tail: Load_C=%b cnt_value=%0d level=%0d expected 1/10/0", Load_C, cnt_value, level); end
    repeat (3) tick();
    cnt_zero = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_idle: busy=%b expected 0", busy); end
    $display("simultaneous push/pop done");
  endtask

  task automatic test_watchdog();
    enable = 1'b1;
    push(4'd3);
    tick();
    tick();
    for (int i = 1; i <= 18; i++) begin
      checks++; if ({Enable_C, timeout} !== 2'b10) begin errors++; $display("FAIL wd_run%0d: Enable_C,timeout=%b expected 10", i, {Enable_C, timeout}); end
      tick();
    end
`ifdef MODULO_ESCALONADOR_WATCHDOG_EN
    checks++; if ({Clear_Reg, timeout} !== 2'b11) begin errors++; $display("FAIL wd_fire: Clear_Reg,timeout=%b expected 11", {Clear_Reg, timeout}); end
    tick();
    checks++; if ({busy, timeout} !== 2'b00) begin errors++; $display("FAIL wd_after: busy,timeout=%b expected 00", {busy, timeout}); end
`else
    checks++; if ({Enable_C, Clear_Reg, timeout} !== 3'b100) begin errors++; $display("FAIL wd_off_stay: Enable_C,Clear_Reg,timeout=%b expected 100", {Enable_C, Clear_Reg, timeout}); end
    tick();
    checks++; if ({Enable_C, timeout} !== 2'b10) begin errors++; $display("FAIL wd_off_stay2: Enable_C,timeout=%b expected 10", {Enable_C, timeout}); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
`endif
    $display("watchdog scenario done");
  endtask

  task automatic test_reset_mid_run();
    enable = 1'b0;
    for (int k = 1; k <= 4; k++) push(4'(k + 4));
    enable = 1'b1;
    tick();
    tick();
    checks++; if ({Enable_C, level} !== {1'b1, 3'd3}) begin errors++; $display("FAIL rst_pre: Enable_C=%b level=%0d expected 1/3", Enable_C, level); end
    rst = 1'b0;
    #1;
    checks++; if ({busy, empty, req_ready, level} !== {3'b011, 3'd0}) begin errors++; $display("FAIL rst_mid_flags: busy,empty,req_ready,level=%b expected 011000", {busy, empty, req_ready, level}); end
    checks++; if ({Load_C, Enable_C, Clear_Reg, cnt_value} !== {3'b000, 4'd0}) begin errors++; $display("FAIL rst_mid_strobes: Load,En,Clr=%b cnt_value=%0d expected 000/0", {Load_C, Enable_C, Clear_Reg}, cnt_value); end
    tick();
    rst = 1'b1;
    tick();
    checks++; if ({busy, empty} !== 2'b01) begin errors++; $display("FAIL rst_after: busy,empty=%b expected 01", {busy, empty}); end
    $display("reset mid-run done");
  endtask

  initial begin
    test_reset_state();
    test_single();
    test_queue_full_back_to_back();
    test_pause_abort();
    test_simultaneous_push_pop();
    test_watchdog();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_escalonador_contador.md
# modulo_escalonador_contador

Scheduler that queues countdown requests and sequences the shared load/enable/clear counter datapath, one request at a time. Requests (a preset value each) are pushed into an internal FIFO; the FSM pops the head, loads the counter, runs it until the counter reports terminal count, clears the register, then serves the next entry. It sits between the request source (buffer/keypad side) and the counter/register datapath, replacing ad-hoc strobe generation.

## Interface
- DATA_W, 4, width of a preset value and of `cnt_value`
- DEPTH, 4, FIFO depth in entries; power of two, ≥ 2
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- enable  in  1  global run enable; low freezes the FSM and pop side
- req_valid  in  1  push request
- req_data  in  DATA_W  preset value to queue
- req_ready  out  1  FIFO can accept (= not full)
- cnt_zero  in  1  counter at terminal count
- abort  in  1  terminate the current countdown early
- cnt_value  out  DATA_W  preset presented to counter load input (registered)
- Load_C  out  1  counter load strobe
- Enable_C  out  1  counter count enable
- Clear_Reg  out  1  register clear strobe
- busy  out  1  FSM not in IDLE
- empty  out  1  FIFO empty
- level  out  $clog2(DEPTH+1)  FIFO occupancy
- timeout  out  1  watchdog fired (see Configuration)

## Operation
- Reset (rst=0, immediate): FSM=IDLE, FIFO empty, level=0, cnt_value=0, Load_C=Enable_C=Clear_Reg=0, busy=0, empty=1, req_ready=1, timeout=0. Reset mid-countdown discards all queued entries.
- State encoding fixed: IDLE=00, LOAD=01, RUN=10, CLEAR=11. Strobes are state decodes ANDed with `enable`: Load_C=LOAD, Enable_C=RUN, Clear_Reg=CLEAR.
- Push: on req_valid & req_ready, write req_data at tail. Push is independent of `enable`. Push when full is ignored; no overwrite.
- Pop: FSM-only, performed on IDLE→LOAD and CLEAR→LOAD transitions; head is registered into cnt_value in the same edge.
- Simultaneous push and pop on a non-empty, non-full FIFO: level unchanged. req_ready depends only on full, not on a same-cycle pop.
- Transitions (only when enable=1; otherwise state, FIFO head and cnt_value hold):
  - IDLE: !empty → LOAD (pop); else stay.
  - LOAD: → RUN unconditionally (exactly one cycle).
  - RUN: cnt_zero | abort → CLEAR; else stay. A preset of 0 exits after one RUN cycle.
  - CLEAR: !empty → LOAD (pop, back-to-back); else → IDLE. Exactly one cycle.
- abort outside RUN is ignored.
- Pointers wrap modulo DEPTH; level saturates at DEPTH by construction.

## Timing
- Push into empty FIFO at edge N → empty=0 after N; LOAD entered at edge N+1 (Load_C high cycle N+1..N+2 with cnt_value valid); RUN from edge N+2.
- cnt_zero sampled in RUN at edge M → Clear_Reg high for one cycle after M.
- Back-to-back: CLEAR → LOAD → RUN, no IDLE gap; inter-request overhead 2 cycles (LOAD+CLEAR).
- enable low mid-RUN: Enable_C drops same cycle (combinational gating), state held; resumes in RUN when enable returns.
- All outputs except strobes' enable gating are registered or decoded from registers; no input→output combinational path other than `enable`.

## Configuration
- MODULO_ESCALONADOR_WATCHDOG_EN defined: a RUN-cycle counter (reset on entering RUN) forces RUN→CLEAR when it reaches 2**DATA_W + 2 enable-qualified cycles without cnt_zero/abort; timeout is high for that CLEAR cycle only.
- Undefined: no watchdog logic; RUN waits indefinitely; timeout tied to 0.

## Test plan
- Reset: drive rst=0 mid-RUN with 3 entries queued → immediately IDLE, level=0, all strobes 0, req_ready=1.
- Single request: push 5 with enable=1, assert cnt_zero 5 cycles into RUN → Load_C one cycle with cnt_value=5, Enable_C for 5 cycles, Clear_Reg one cycle, then IDLE, busy=0.
- Queue full/back-to-back: push 1,2,3,4 then 9 → 9 rejected (req_ready=0, level=4); served in order 1,2,3,4 with CLEAR→LOAD direct, no IDLE between.
- Pause/abort: enable=0 for 3 cycles in RUN → Enable_C=0, state held; abort in RUN → CLEAR next edge, next entry loaded.
- Simultaneous push/pop at level=2 in CLEAR → level stays 2, popped value on cnt_value, pushed value at tail.
- Watchdog (macro defined, DATA_W=4): hold cnt_zero=0 in RUN → CLEAR after 18 RUN cycles with timeout=1 for one cycle; macro undefined → stays in RUN, timeout=0.
